enigma_msg_ctrl: RTL and testbench
==================================

ENIGMA_MSG_CTRL -- requirements
Module: enigma_msg_ctrl

Interface
REQ-001 SHALL have parameter CORE_LAT, default 1, range 1..4: cycles from core_valid_o to a valid core_symb_i.
REQ-002 SHALL have parameter CNT_W, default 16: width of msg_cnt_o.
REQ-003 clk_i  in  1  single clock; all logic on posedge.
REQ-004 rst_i  in  1  reset, synchronous, active-high.
REQ-005 cfg_valid_i / cfg_ready_o  in/out  1/1  key-setup handshake.
REQ-006 cfg_pos_i  in  15  start positions {r3[14:10], r2[9:5], r1[4:0]}, each 1..26.
REQ-007 sym_valid_i / sym_ready_o / sym_last_i  in/out/in  1/1/1  plaintext handshake and last-letter flag.
REQ-008 sym_i  in  7  letter code, 1..26 = A..Z.
REQ-009 core_valid_o / core_symb_o  out  1/7  one-cycle strobe and letter sent to the cipher core.
REQ-010 core_symb_i  in  7  enciphered letter returned by the core.
REQ-011 r1_pos_o, r2_pos_o, r3_pos_o  out  5 each  rotor positions driven to the core.
REQ-012 out_valid_o / out_ready_i / out_symb_o / out_last_o  out/in/out/out  1/1/7/1  ciphertext handshake.
REQ-013 busy_o / err_o / msg_cnt_o  out  1/1/CNT_W  status, one-cycle error pulse, letters-enciphered count.

Function
REQ-014 SHALL implement FSM IDLE, RUN, WAIT, OUT; exactly one letter in flight.
REQ-015 IDLE: cfg_ready_o=1; on cfg_valid_i, load positions, clear msg_cnt_o, go RUN.
REQ-016 A cfg_pos_i field of 0 or >26 SHALL load as 1 and pulse err_o for one cycle.
REQ-017 RUN: sym_ready_o=1; on handshake with a valid letter, register core_symb_o=sym_i, pulse core_valid_o next cycle, step rotors on the same edge, go WAIT.
REQ-018 Stepping SHALL precede enciphering: r*_pos_o show the post-step values in the core_valid_o cycle and hold until the next accepted letter.
REQ-019 Odometer: r1 +1 per letter; 26->1 wraps; r1 wrap SHALL step r2; r2 wrap in the same step SHALL step r3; r3 26->1 wraps freely.
REQ-020 A sym_i of 0 or >26 SHALL bypass the core and rotors: go directly to OUT with out_symb_o=sym_i, no step, no count, err_o pulse.
REQ-021 WAIT: hold exactly CORE_LAT cycles after core_valid_o, capture core_symb_i into out_symb_o, go OUT.
REQ-022 OUT: out_valid_o=1 with stable out_symb_o/out_last_o until out_ready_i; then msg_cnt_o +1 (saturating at all-ones; bypassed symbols excluded); go IDLE if out_last_o else RUN.
REQ-023 out_last_o SHALL equal sym_last_i captured with the letter.
REQ-024 sym_ready_o and cfg_ready_o SHALL be 0 outside RUN and IDLE respectively; cfg_valid_i outside IDLE SHALL be ignored.
REQ-025 busy_o SHALL be 1 in every state except IDLE.
REQ-026 Minimum throughput: one letter per CORE_LAT+3 cycles with out_ready_i held high.

Reset
REQ-027 rst_i high SHALL force IDLE and zero every output except r1/r2/r3_pos_o=1 and cfg_ready_o=1, aborting any letter in flight without output.
REQ-028 rst_i asserted together with any handshake SHALL take priority; the handshake is lost.

Configuration
REQ-029 Macro ENIGMA_DOUBLE_STEP_EN defined: if r2 is 25 before a step, r2 and r3 SHALL both step on that letter regardless of r1 (double-step anomaly), in addition to REQ-019.
REQ-030 Macro undefined: pure odometer stepping per REQ-019 only.

Verification
REQ-031 Reset, then cfg_pos {1,1,1}, one letter 1 -> core_symb_o=1 with positions {1,1,2}; returned core value appears on out_symb_o after CORE_LAT cycles.
REQ-032 Start {1,1,26}, one letter -> positions {1,2,1}; start {1,26,26} -> {2,1,1}.
REQ-033 ENIGMA_DOUBLE_STEP_EN: start {1,25,3}, one letter -> {2,26,4}; macro undefined -> {1,25,4}.
REQ-034 sym_i=0 then sym_i=27 -> both passed through unchanged, err_o pulses twice, positions and msg_cnt_o unchanged.
REQ-035 out_ready_i held low 10 cycles in OUT -> out_symb_o stable, sym_ready_o=0; release -> next letter accepted; last=1 returns IDLE with msg_cnt_o=letters sent.
REQ-036 rst_i asserted in WAIT -> next cycle IDLE, out_valid_o=0, positions {1,1,1}, msg_cnt_o=0.

Source files
------------

// File: rtl/enigma_msg_ctrl.sv
// enigma_msg_ctrl
//   Message sequencer for an Enigma-style cipher core. It takes the rotor start
//   positions, accepts one plaintext letter at a time, steps the rotors, hands
//   the letter to the core and returns the enciphered letter. Exactly one letter
//   is in flight at any time.
//
//   Build option: define ENIGMA_DOUBLE_STEP_EN to enable the middle-rotor
//   double-step anomaly. When it is undefined, the rotors step as a plain
//   odometer.
//
// Ports
//   clk_i, rst_i               : clock; synchronous active-high reset
//   cfg_valid_i/cfg_ready_o    : key setup handshake; cfg_pos_i = {r3,r2,r1}
//   sym_valid_i/sym_ready_o    : plaintext handshake; sym_i letter, sym_last_i
//   core_valid_o/core_symb_o   : one-cycle strobe and letter sent to the core
//   core_symb_i                : core result, valid CORE_LAT cycles after strobe
//   r1/r2/r3_pos_o             : rotor positions driven to the core
//   out_valid_o/out_ready_i    : ciphertext handshake; out_symb_o, out_last_o
//   busy_o, err_o, msg_cnt_o   : status, one-cycle error pulse, letter count
//
// States
//   IDLE | waiting for key setup
//   RUN  | ready for the next plaintext letter
//   WAIT | letter is in the core; counting down the core latency
//   OUT  | result is presented on the output handshake
module enigma_msg_ctrl #(
  parameter int CORE_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [14:0]      cfg_pos_i,
  input  logic             sym_valid_i,
  output logic             sym_ready_o,
  input  logic             sym_last_i,
  input  logic [6:0]       sym_i,
  output logic             core_valid_o,
  output logic [6:0]       core_symb_o,
  input  logic [6:0]       core_symb_i,
  output logic [4:0]       r1_pos_o,
  output logic [4:0]       r2_pos_o,
  output logic [4:0]       r3_pos_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [6:0]       out_symb_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] msg_cnt_o
);

  localparam int LAT_W = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WAIT, ST_OUT} state_t;

  state_t             state_q, state_d;
  logic [4:0]         r1_q, r1_d, r2_q, r2_d, r3_q, r3_d;
  logic [6:0]         core_symb_q, core_symb_d;
  logic               core_valid_q, core_valid_d;
  logic [6:0]         out_symb_q, out_symb_d;
  logic               out_last_q, out_last_d;
  logic               bypass_q, bypass_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic               err_q, err_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               sym_ready_q, sym_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic r1_wrap, r2_step, r2_wrap, r3_step, dbl_step;
  logic sym_ok;

  function automatic logic pos_bad(input logic [4:0] p);
    return (p == 5'd0) || (p > 5'd26);
  endfunction

  function automatic logic [4:0] pos_inc(input logic [4:0] p);
    return (p == 5'd26) ? 5'd1 : p + 5'd1;
  endfunction

  // Step decisions are taken on the pre-step positions.
  always_comb begin
`ifdef ENIGMA_DOUBLE_STEP_EN
    dbl_step = (r2_q == 5'd25);
`else
    dbl_step = 1'b0;
`endif
    r1_wrap = (r1_q == 5'd26);
    r2_step = r1_wrap | dbl_step;
    r2_wrap = r2_step & (r2_q == 5'd26);
    r3_step = r2_wrap | dbl_step;
  end

  assign sym_ok = (sym_i != 7'd0) && (sym_i <= 7'd26);

  always_comb begin
    state_d      = state_q;
    r1_d         = r1_q;
    r2_d         = r2_q;
    r3_d         = r3_q;
    core_symb_d  = core_symb_q;
    core_valid_d = 1'b0;
    out_symb_d   = out_symb_q;
    out_last_d   = out_last_q;
    bypass_d     = bypass_q;
    lat_d        = lat_q;
    msg_cnt_d    = msg_cnt_q;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid_i) begin
          r1_d      = pos_bad(cfg_pos_i[4:0])   ? 5'd1 : cfg_pos_i[4:0];
          r2_d      = pos_bad(cfg_pos_i[9:5])   ? 5'd1 : cfg_pos_i[9:5];
          r3_d      = pos_bad(cfg_pos_i[14:10]) ? 5'd1 : cfg_pos_i[14:10];
          err_d     = pos_bad(cfg_pos_i[4:0]) | pos_bad(cfg_pos_i[9:5]) |
                      pos_bad(cfg_pos_i[14:10]);
          msg_cnt_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (sym_valid_i) begin
          out_last_d = sym_last_i;
          if (sym_ok) begin
            core_symb_d  = sym_i;
            core_valid_d = 1'b1;
            r1_d         = pos_inc(r1_q);
            r2_d         = r2_step ? pos_inc(r2_q) : r2_q;
            r3_d         = r3_step ? pos_inc(r3_q) : r3_q;
            bypass_d     = 1'b0;
            lat_d        = LAT_W'(CORE_LAT);
            state_d      = ST_WAIT;
          end else begin
            // Not a letter: echo it straight out, leave rotors and count alone.
            out_symb_d = sym_i;
            bypass_d   = 1'b1;
            err_d      = 1'b1;
            state_d    = ST_OUT;
          end
        end
      end
      ST_WAIT: begin
        if (lat_q == '0) begin
          out_symb_d = core_symb_i;
          state_d    = ST_OUT;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          if (!bypass_q && (msg_cnt_q != '1)) msg_cnt_d = msg_cnt_q + CNT_W'(1);
          state_d = out_last_q ? ST_IDLE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cfg_ready_d = (state_d == ST_IDLE);
    sym_ready_d = (state_d == ST_RUN);
    out_valid_d = (state_d == ST_OUT);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      r1_q         <= 5'd1;
      r2_q         <= 5'd1;
      r3_q         <= 5'd1;
      core_symb_q  <= '0;
      core_valid_q <= 1'b0;
      out_symb_q   <= '0;
      out_last_q   <= 1'b0;
      bypass_q     <= 1'b0;
      lat_q        <= '0;
      msg_cnt_q    <= '0;
      err_q        <= 1'b0;
      cfg_ready_q  <= 1'b1;
      sym_ready_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      r1_q         <= r1_d;
      r2_q         <= r2_d;
      r3_q         <= r3_d;
      core_symb_q  <= core_symb_d;
      core_valid_q <= core_valid_d;
      out_symb_q   <= out_symb_d;
      out_last_q   <= out_last_d;
      bypass_q     <= bypass_d;
      lat_q        <= lat_d;
      msg_cnt_q    <= msg_cnt_d;
      err_q        <= err_d;
      cfg_ready_q  <= cfg_ready_d;
      sym_ready_q  <= sym_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign cfg_ready_o  = cfg_ready_q;
  assign sym_ready_o  = sym_ready_q;
  assign core_valid_o = core_valid_q;
  assign core_symb_o  = core_symb_q;
  assign r1_pos_o     = r1_q;
  assign r2_pos_o     = r2_q;
  assign r3_pos_o     = r3_q;
  assign out_valid_o  = out_valid_q;
  assign out_symb_o   = out_symb_q;
  assign out_last_o   = out_last_q;
  assign busy_o       = busy_q;
  assign err_o        = err_q;
  assign msg_cnt_o    = msg_cnt_q;

endmodule

// File: tb/tb_enigma_msg_ctrl.sv
// Directed bench for enigma_msg_ctrl. A small core model answers CORE_LAT
// cycles after each core strobe with 27 - letter and drives 0x7f otherwise.
module tb_enigma_msg_ctrl;

  localparam int CORE_LAT = 1;
  localparam int CNT_W    = 16;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             cfg_valid_i = 1'b0;
  logic             cfg_ready_o;
  logic [14:0]      cfg_pos_i = '0;
  logic             sym_valid_i = 1'b0;
  logic             sym_ready_o;
  logic             sym_last_i = 1'b0;
  logic [6:0]       sym_i = '0;
  logic             core_valid_o;
  logic [6:0]       core_symb_o;
  logic [6:0]       core_symb_i;
  logic [4:0]       r1_pos_o, r2_pos_o, r3_pos_o;
  logic             out_valid_o;
  logic             out_ready_i = 1'b0;
  logic [6:0]       out_symb_o;
  logic             out_last_o;
  logic             busy_o, err_o;
  logic [CNT_W-1:0] msg_cnt_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  enigma_msg_ctrl #(.CORE_LAT(CORE_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o), .cfg_pos_i(cfg_pos_i),
    .sym_valid_i(sym_valid_i), .sym_ready_o(sym_ready_o), .sym_last_i(sym_last_i),
    .sym_i(sym_i), .core_valid_o(core_valid_o), .core_symb_o(core_symb_o),
    .core_symb_i(core_symb_i), .r1_pos_o(r1_pos_o), .r2_pos_o(r2_pos_o),
    .r3_pos_o(r3_pos_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_symb_o(out_symb_o), .out_last_o(out_last_o), .busy_o(busy_o),
    .err_o(err_o), .msg_cnt_o(msg_cnt_o)
  );

  // Core model: result is valid only in the cycle CORE_LAT after the strobe.
  logic [3:0] mlat  = '0;
  logic [6:0] mheld = '0;
  always @(posedge clk) begin
    if (core_valid_o) begin
      mlat  <= 4'd1;
      mheld <= core_symb_o;
    end else if (mlat != 4'd0 && mlat < 4'd8) begin
      mlat <= mlat + 4'd1;
    end else begin
      mlat <= 4'd0;
    end
  end
  assign core_symb_i = (mlat == 4'(CORE_LAT)) ? (7'd27 - mheld) : 7'h7f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int r3, input int r2, input int r1);
    return {17'd0, 5'(r3), 5'(r2), 5'(r1)};
  endfunction

  function automatic logic [31:0] pos_now();
    return {17'd0, r3_pos_o, r2_pos_o, r1_pos_o};
  endfunction

  task automatic cfg(input int r3, input int r2, input int r1);
    int n;
    n = 0;
    while (!cfg_ready_o && n < 20) begin tick; n++; end
    chk("cfg_ready", cfg_ready_o, 1);
    cfg_pos_i   = {5'(r3), 5'(r2), 5'(r1)};
    cfg_valid_i = 1'b1;
    tick;
    cfg_valid_i = 1'b0;
    chk("cfg_ready_run", cfg_ready_o, 0);
    chk("busy_run", busy_o, 1);
    chk("sym_ready_run", sym_ready_o, 1);
  endtask

  task automatic send(input logic [6:0] s, input bit last, input logic [6:0] exp_out,
                      input logic [31:0] exp_pos, input int hold);
    int n;
    bit byp;
    byp = (s == 7'd0) || (s > 7'd26);
    n = 0;
    while (!sym_ready_o && n < 20) begin tick; n++; end
    chk("sym_ready", sym_ready_o, 1);
    sym_valid_i = 1'b1;
    sym_i       = s;
    sym_last_i  = last;
    tick;
    sym_valid_i = 1'b0;
    sym_i       = '0;
    sym_last_i  = 1'b0;
    chk("sym_ready_busy", sym_ready_o, 0);
    if (!byp) begin
      chk("core_valid", core_valid_o, 1);
      chk("core_symb", core_symb_o, s);
      chk("pos_step", pos_now(), exp_pos);
      chk("err_clean", err_o, 0);
    end else begin
      chk("core_valid_byp", core_valid_o, 0);
      chk("err_byp", err_o, 1);
    end
    n = 0;
    while (!out_valid_o && n < 20) begin tick; n++; end
    chk("out_lat", n, byp ? 0 : CORE_LAT + 1);
    chk("out_symb", out_symb_o, exp_out);
    chk("out_last", out_last_o, last);
    chk("pos_hold", pos_now(), exp_pos);
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("hold_valid", out_valid_o, 1);
      chk("hold_symb", out_symb_o, exp_out);
      chk("hold_sym_ready", sym_ready_o, 0);
    end
    out_ready_i = 1'b1;
    tick;
    out_ready_i = 1'b0;
    chk("out_valid_clr", out_valid_o, 0);
    chk("err_clr", err_o, 0);
    chk("next_state_idle", cfg_ready_o, last);
    chk("next_state_run", sym_ready_o, !last);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    tick; tick;
    chk("rst_cfg_ready", cfg_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_pos", pos_now(), pk(1, 1, 1));
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_sym_ready", sym_ready_o, 0);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_msg_cnt", msg_cnt_o, 0);
    chk("rst_err", err_o, 0);
    rst_i = 1'b0;
    tick;
    chk("idle_cfg_ready", cfg_ready_o, 1);

    // Basic letters from {1,1,1}; a cfg request in RUN must be ignored.
    cfg(1, 1, 1);
    chk("cfg_err_none", err_o, 0);
    cfg_pos_i   = {5'd9, 5'd9, 5'd9};
    cfg_valid_i = 1'b1;
    tick;
    cfg_valid_i = 1'b0;
    chk("cfg_ignored_pos", pos_now(), pk(1, 1, 1));
    chk("cfg_ignored_run", sym_ready_o, 1);
    send(7'd1, 1'b0, 7'd26, pk(1, 1, 2), 0);
    chk("cnt_1", msg_cnt_o, 1);
    send(7'd5, 1'b1, 7'd22, pk(1, 1, 3), 0);
    chk("cnt_2", msg_cnt_o, 2);
    chk("idle_busy", busy_o, 0);

    // Odometer carries.
    cfg(1, 1, 26);
    send(7'd3, 1'b1, 7'd24, pk(1, 2, 1), 0);
    cfg(1, 26, 26);
    send(7'd4, 1'b1, 7'd23, pk(2, 1, 1), 0);
    cfg(1, 25, 3);
`ifdef ENIGMA_DOUBLE_STEP_EN
    send(7'd7, 1'b1, 7'd20, pk(2, 26, 4), 0);
`else
    send(7'd7, 1'b1, 7'd20, pk(1, 25, 4), 0);
`endif

    // Out-of-range start positions load as 1 with an error pulse.
    cfg(0, 27, 5);
    chk("cfg_err", err_o, 1);
    chk("cfg_fix_pos", pos_now(), pk(1, 1, 5));
    chk("cfg_cnt_clr", msg_cnt_o, 0);
    tick;
    chk("cfg_err_pulse", err_o, 0);

    // Bypassed symbols, backpressure, then last letter.
    send(7'd0, 1'b0, 7'd0, pk(1, 1, 5), 0);
    send(7'd27, 1'b0, 7'd27, pk(1, 1, 5), 0);
    chk("byp_cnt", msg_cnt_o, 0);
    send(7'd10, 1'b0, 7'd17, pk(1, 1, 6), 10);
    send(7'd2, 1'b1, 7'd25, pk(1, 1, 7), 0);
    chk("msg_cnt_final", msg_cnt_o, 2);
    chk("final_idle", busy_o, 0);

    // Reset while a letter is in the core.
    cfg(3, 4, 5);
    send(7'd8, 1'b0, 7'd19, pk(3, 4, 6), 0);
    chk("pre_rst_cnt", msg_cnt_o, 1);
    sym_valid_i = 1'b1;
    sym_i       = 7'd9;
    tick;
    sym_valid_i = 1'b0;
    sym_i       = '0;
    chk("wait_core_valid", core_valid_o, 1);
    rst_i = 1'b1;
    tick;
    rst_i = 1'b0;
    chk("abort_out_valid", out_valid_o, 0);
    chk("abort_cfg_ready", cfg_ready_o, 1);
    chk("abort_busy", busy_o, 0);
    chk("abort_pos", pos_now(), pk(1, 1, 1));
    chk("abort_cnt", msg_cnt_o, 0);
    chk("abort_core_valid", core_valid_o, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort_no_out", out_valid_o, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
